conv_frame_sequencer: RTL

Frame-level sequencer for the 3x3 convolution pipeline. It sits between the upstream AXI-stream pixel source and the line-buffer controller. It admits exactly one frame per `start` and forwards accepted pixels to the line buffers. Input is throttled on output-FIFO fullness and on line-buffer reuse, so an unread row is never overwritten. It counts output beats to raise per-line and end-of-frame events.

---
 rtl/conv_frame_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for the 3x3 convolution pipeline: admits one frame per start,
// throttles input on FIFO fullness and line-buffer reuse, and counts output beats.
module conv_frame_sequencer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int LB_LINES   = 4,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic          axi_clk,
  input  logic          axi_reset_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  input  logic          fifo_prog_full,
  output logic          lb_wr_en,
  output logic [7:0]    lb_data,
  input  logic          out_beat,
  output logic          busy,
  output logic          line_irq,
  output logic          frame_done,
  output logic [RW-1:0] in_row,
  output logic [RW-1:0] out_row,
  output logic          seq_err
);

  // Two spare bits so row arithmetic (row + 3, row + LB_LINES-1) cannot wrap.
  localparam int XW = RW + 2;

  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] OUT_LAST_ROW = RW'(IMG_HEIGHT - 3);
  localparam logic [RW-1:0] OUT_DONE_ROW = RW'(IMG_HEIGHT - 2);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] in_col;
  logic [CW-1:0] out_col;

  logic          start_ok;
  logic          accept;
  logic          last_col_in;
  logic          last_pixel;
  logic          counting;
  logic          out_wrap;
  logic          out_done;
  logic          out_done_next;
  logic          row_err;
  logic          beat_ok;
  logic          beat_err;
  logic [XW-1:0] rows_avail;

  assign start_ok    = (state == IDLE) && start;
  assign last_col_in = (in_col == COL_LAST);
  assign last_pixel  = last_col_in && (in_row == ROW_LAST);

  assign s_ready = (state == ACCEPT) && !fifo_prog_full &&
                   (XW'(in_row) <= XW'(out_row) + XW'(LB_LINES - 1));
  assign accept  = s_valid && s_ready;

  assign counting = (state == ACCEPT) || (state == DRAIN);
  assign out_wrap = (out_col == COL_LAST);
  assign out_done = (out_row == OUT_DONE_ROW);

  // A row completed by an accept in this same cycle already counts as received.
  assign rows_avail = (state == DRAIN) ? XW'(IMG_HEIGHT)
                                       : XW'(in_row) + XW'(accept && last_col_in);
  assign row_err    = out_wrap && (XW'(out_row) + XW'(3) > rows_avail);

  assign beat_ok       = out_beat && counting && !out_done && !row_err;
  assign beat_err      = out_beat && !beat_ok;
  assign out_done_next = out_done || (beat_ok && out_wrap && (out_row == OUT_LAST_ROW));

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCEPT;
      ACCEPT:  if (accept && last_pixel) state_next = out_done_next ? DONE : DRAIN;
      DRAIN:   if (out_done_next) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The final pixel leaves in_row at the last row so it holds a meaningful value.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      in_col  <= '0;
      in_row  <= '0;
      out_col <= '0;
      out_row <= '0;
      seq_err <= 1'b0;
    end else if (start_ok) begin
      in_col  <= '0;
      in_row  <= '0;
      out_col <= '0;
      out_row <= '0;
      seq_err <= 1'b0;
    end else begin
      if (accept) begin
        if (last_col_in) begin
          in_col <= '0;
          if (!last_pixel) in_row <= in_row + RW'(1);
        end else begin
          in_col <= in_col + CW'(1);
        end
      end
      if (beat_ok) begin
        if (out_wrap) begin
          out_col <= '0;
          out_row <= out_row + RW'(1);
        end else begin
          out_col <= out_col + CW'(1);
        end
      end
      if (beat_err) seq_err <= 1'b1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      lb_wr_en <= 1'b0;
      lb_data  <= 8'd0;
      line_irq <= 1'b0;
    end else begin
      lb_wr_en <= accept;
      line_irq <= beat_ok && out_wrap;
      if (accept) lb_data <= s_data;
    end
  end

endmodule
